// File: rtl/flag_selector.sv
// rtl/flag_selector.sv - debounced button commands and optional slideshow stepping of a flag index
// Auto-advance (vsync frame counter) is present only when FLAG_SELECTOR_AUTO_EN is defined.
module flag_selector #(
  parameter int DEBOUNCE_BITS = 16,
  parameter int AUTO_FRAMES   = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_home,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_load,
  input  logic [6:0] load_value,
  input  logic [6:0] max_index,
  input  logic       auto_en,
  output logic [6:0] index,
  output logic       changed
);

  // Encoding order doubles as priority: a larger code outranks a smaller one.
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_LOAD = 3'd1,
    CMD_PREV = 3'd2,
    CMD_NEXT = 3'd3,
    CMD_HOME = 3'd4
  } cmd_e;

  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q [4];
  logic [DEBOUNCE_BITS-1:0] cnt_d [4];
  cmd_e       cmd_q, cmd_d, press_cmd;
  logic       exec;
  logic       auto_step;
  logic [6:0] index_q, index_d, next_idx, prev_idx, load_idx;
  logic       changed_q, changed_d;

  assign btn_raw = {btn_load, btn_prev, btn_next, btn_home};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (&cnt_q[i]) deb_d[i] = sync2_q[i];
        else           cnt_d[i] = cnt_q[i] + DEBOUNCE_BITS'(1);
      end
    end
  end

  always_comb begin
    press_cmd = CMD_NONE;
    if      (deb_q[0]) press_cmd = CMD_HOME;
    else if (deb_q[1]) press_cmd = CMD_NEXT;
    else if (deb_q[2]) press_cmd = CMD_PREV;
    else if (deb_q[3]) press_cmd = CMD_LOAD;

    cmd_d = cmd_q;
    exec  = 1'b0;
    if (deb_q == 4'b0000) begin
      exec  = (cmd_q != CMD_NONE);
      cmd_d = CMD_NONE;
    end else if (press_cmd > cmd_q) begin
      cmd_d = press_cmd;
    end
  end

`ifdef FLAG_SELECTOR_AUTO_EN
  localparam int FRAME_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  logic               vsync_q, vsync_d, frame_edge;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    vsync_d    = vsync;
    frame_edge = vsync && !vsync_q;
    frame_d    = frame_q;
    auto_step  = 1'b0;
    if (!auto_en || exec) begin
      frame_d = '0;
    end else if (frame_edge) begin
      if (frame_q == FRAME_W'(AUTO_FRAMES - 1)) begin
        auto_step = 1'b1;
        frame_d   = '0;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      frame_q <= '0;
    end else begin
      vsync_q <= vsync_d;
      frame_q <= frame_d;
    end
  end
`else
  logic unused_auto;
  assign unused_auto = vsync ^ auto_en;
  assign auto_step   = 1'b0;
`endif

  always_comb begin
    next_idx  = (index_q >= max_index) ? 7'd0 : index_q + 7'd1;
    prev_idx  = (index_q == 7'd0 || index_q > max_index) ? max_index : index_q - 7'd1;
    load_idx  = (load_value > max_index) ? max_index : load_value;
    index_d   = index_q;
    if (exec) begin
      case (cmd_q)
        CMD_HOME: index_d = 7'd0;
        CMD_NEXT: index_d = next_idx;
        CMD_PREV: index_d = prev_idx;
        CMD_LOAD: index_d = load_idx;
        default:  index_d = index_q;
      endcase
    end else if (auto_step) begin
      index_d = next_idx;
    end
    changed_d = (index_d != index_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      cmd_q     <= CMD_NONE;
      index_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      cmd_q     <= cmd_d;
      index_q   <= index_d;
      changed_q <= changed_d;
    end
  end

  assign index   = index_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_flag_selector.sv
// tb/tb_flag_selector.sv - scoreboard bench for flag_selector (DEBOUNCE_BITS=2, AUTO_FRAMES=3)
module tb_flag_selector;

`ifdef FLAG_SELECTOR_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic [3:0] btn;
  logic [6:0] load_value;
  logic [6:0] max_idx;
  logic       auto_en;
  logic [6:0] index;
  logic       changed;

  int checks   = 0;
  int failures = 0;
  logic [6:0] exp_q [$];
  logic [6:0] exp_idx;
  int lat;
  bit seen;

  always #5 clk = ~clk;

  flag_selector #(.DEBOUNCE_BITS(2), .AUTO_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .btn_home(btn[0]), .btn_next(btn[1]), .btn_prev(btn[2]), .btn_load(btn[3]),
    .load_value(load_value), .max_index(max_idx), .auto_en(auto_en),
    .index(index), .changed(changed)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] m_next(input logic [6:0] i, input logic [6:0] m);
    return (i >= m) ? 7'd0 : i + 7'd1;
  endfunction

  function automatic logic [6:0] m_prev(input logic [6:0] i, input logic [6:0] m);
    return (i == 7'd0 || i > m) ? m : i - 7'd1;
  endfunction

  task automatic expect_idx(input logic [6:0] nv);
    if (nv != exp_idx) exp_q.push_back(nv);
    exp_idx = nv;
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk) btn = m;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic press2(input logic [3:0] first, input logic [3:0] both);
    @(negedge clk) btn = first;
    repeat (10) @(negedge clk);
    btn = both;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Each changed pulse must correspond to the oldest predicted index update.
  always @(negedge clk) begin
    if (!reset && changed) begin
      if (exp_q.size() == 0) check_eq("chg_spurious_q", exp_q.size(), 1);
      else                   check_eq("chg_idx", index, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; vsync = 1'b0; btn = 4'b0000;
    load_value = 7'd0; max_idx = 7'd5; auto_en = 1'b0; exp_idx = 7'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_index", index, 0);
    check_eq("rst_changed", changed, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    load_value = 7'd5;
    expect_idx(load_value);
    press(4'b1000);
    check_eq("load5", index, exp_idx);

    // next wraps 5 -> 0; release-to-update latency is 2 + 4 + 1 edges
    expect_idx(m_next(exp_idx, max_idx));
    @(negedge clk) btn = 4'b0010;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (changed) begin seen = 1'b1; lat = k; end
    end
    check_eq("latency", lat, 7);
    repeat (5) @(negedge clk);
    check_eq("next_wrap", index, exp_idx);

    expect_idx(m_prev(exp_idx, max_idx));
    press(4'b0100);
    check_eq("prev_wrap", index, exp_idx);

    load_value = 7'd9;
    expect_idx((load_value > max_idx) ? max_idx : load_value);
    press(4'b1000);
    check_eq("load_clamp", index, exp_idx);

    max_idx = 7'd2;
    repeat (5) @(negedge clk);
    check_eq("max_drop_hold", index, exp_idx);
    expect_idx(m_prev(exp_idx, max_idx));
    press(4'b0100);
    check_eq("prev_above_max", index, exp_idx);
    expect_idx(m_next(exp_idx, max_idx));
    press(4'b0010);
    check_eq("next_at_max", index, exp_idx);
    max_idx = 7'd5;

    expect_idx(m_next(exp_idx, max_idx));
    press(4'b0010);
    check_eq("next_inc", index, exp_idx);
    expect_idx(7'd0);
    press2(4'b0010, 4'b0011);
    check_eq("home_overrides", index, exp_idx);
    expect_idx(7'd0);
    press2(4'b0001, 4'b0011);
    check_eq("home_kept", index, exp_idx);
    load_value = 7'd3;
    expect_idx(m_prev(exp_idx, max_idx));
    press2(4'b0100, 4'b1100);
    check_eq("prev_over_load", index, exp_idx);

    for (int g = 0; g < 5; g++) begin
      @(negedge clk) btn = 4'b0010;
      @(negedge clk) btn = 4'b0000;
      repeat (3) @(negedge clk);
    end
    repeat (15) @(negedge clk);
    check_eq("bounce", index, exp_idx);

    auto_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int f = 1; f <= 6; f++) begin
      if (AUTO && (f % 3 == 0)) expect_idx(m_next(exp_idx, max_idx));
      vsync_pulse();
      if (f % 3 == 0) check_eq("auto_step", index, exp_idx);
    end

    // Command execution lands on the third frame edge: only the command applies.
    vsync_pulse();
    vsync_pulse();
    expect_idx(m_prev(exp_idx, max_idx));
    @(negedge clk) btn = 4'b0100;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (6) @(posedge clk);
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) vsync = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("cmd_beats_auto", index, exp_idx);
    vsync_pulse();
    vsync_pulse();
    check_eq("frame_cnt_reset", index, exp_idx);
    if (AUTO) expect_idx(m_next(exp_idx, max_idx));
    vsync_pulse();
    check_eq("auto_after_cmd", index, exp_idx);
    auto_en = 1'b0;
    vsync_pulse();
    vsync_pulse();
    vsync_pulse();
    check_eq("auto_off", index, exp_idx);

    // Reset while next is latched, released during reset: nothing executes.
    @(negedge clk) btn = 4'b0010;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_idx = 7'd0;
    repeat (2) @(negedge clk);
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("rst_discard", index, exp_idx);

    // Held through reset: re-debounces and executes once on release.
    @(negedge clk) btn = 4'b0010;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_idx(m_next(exp_idx, max_idx));
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    repeat (12) @(negedge clk);
    check_eq("rst_redebounce", index, exp_idx);

    check_eq("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_selector.md
FLAG_SELECTOR -- requirements
Module: flag_selector

Interface
REQ-001 Parameter DEBOUNCE_BITS, default 16: button held stable for 2^DEBOUNCE_BITS clk cycles before its debounced state changes.
REQ-002 Parameter AUTO_FRAMES, default 300: frame edges between auto-advance steps (5 s at 60 Hz).
REQ-003 Port clk  input  1  pixel clock; the only clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port vsync  input  1  vsync from hvsync_generator, same clock domain.
REQ-006 Port btn_home / btn_next / btn_prev / btn_load  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 Port load_value  input  7  index loaded by the load command.
REQ-008 Port max_index  input  7  highest valid flag index, driven by flag_index.
REQ-009 Port auto_en  input  1  enables slideshow auto-advance.
REQ-010 Port index  output  7  registered flag index feeding flag_index.
REQ-011 Port changed  output  1  one-cycle pulse in the first cycle a new index value is visible.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer: per-button DEBOUNCE_BITS-wide counter, cleared whenever the synced input equals the debounced state; the debounced state flips when the counter saturates.
REQ-013 Command latch SHALL record, on any debounced-high button, the highest-priority pressed command: home > next > prev > load; a later higher-priority press while held SHALL overwrite it, a lower one SHALL not.
REQ-014 The latched command SHALL execute in the first cycle all four debounced buttons are low, then the latch SHALL clear (execute-on-release, one execution per press).
REQ-015 home: index <= 0.
REQ-016 next: index <= (index >= max_index) ? 0 : index+1.
REQ-017 prev: index <= (index == 0 || index > max_index) ? max_index : index-1.
REQ-018 load: index <= min(load_value, max_index), sampled in the execute cycle.
REQ-019 Frame edge SHALL be vsync rising edge (high now, low previous cycle), detected with one register.
REQ-020 Frame counter SHALL increment on each frame edge; when auto_en=1 and counter = AUTO_FRAMES-1 at a frame edge, apply next and reset counter to 0.
REQ-021 auto_en=0 SHALL hold the frame counter at 0.
REQ-022 Any command execution SHALL reset the frame counter to 0; if command execution and auto-advance coincide, the command wins and auto-advance is discarded.
REQ-023 If max_index drops below index with no command pending, index SHALL hold; the next command or auto-advance applies REQ-015..018 rules.
REQ-024 changed SHALL be 1 exactly in the cycle after any index register update whose new value differs from old; never for an unchanged value (e.g. home at 0).
REQ-025 Latency: last button release (synced input low) to index update = 2 sync + 2^DEBOUNCE_BITS debounce + 1 cycles.

Reset
REQ-026 While reset=1 at a clk edge: index=0, changed=0, command latch empty, synchronizers, debounced states and debounce counters 0, frame counter 0, vsync edge register 0.
REQ-027 Reset mid-press SHALL discard the latched command; a button still held after reset SHALL debounce afresh and execute on its release.

Configuration
REQ-028 Macro FLAG_SELECTOR_AUTO_EN defined: frame counter, vsync edge detect and auto-advance present per REQ-019..022.
REQ-029 Macro undefined: that logic SHALL be absent, auto_en and vsync unused, index changes only by commands; all other behaviour identical.

Verification (DEBOUNCE_BITS=2, AUTO_FRAMES=3)
REQ-030 max_index=5, index=5, press/release next -> index=0, changed pulses once, counted latency per REQ-025.
REQ-031 index=0, press/release prev -> index=5; press load with load_value=9 -> index=5.
REQ-032 Hold next, then add home, release both -> index=0; hold home, add next -> still home.
REQ-033 Bounce next 1-cycle glitches (shorter than 4 cycles) -> no latch, index unchanged.
REQ-034 auto_en=1, 3 vsync rising edges -> index increments once per 3 frames; command on the auto frame -> only command applied; macro undefined -> no auto change.
REQ-035 Assert reset while next held and latched -> index=0, no execution on release of pre-reset press unless re-debounced post-reset.
